// File: rtl/pi_decoder_module.sv
// Inverse 5x5 bit permutation: walks one cell per clock, d[x][y] = e[y][(2x+3y) mod 5].
// Optionally repeats the pass ROUNDS times by copying the result back into the work plane.
module pi_decoder_module #(
  parameter int memsize = 25,
  parameter int ROUNDS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [memsize-1:0] line,
  output logic               busy,
  output logic               done,
  output logic [memsize-1:0] mem,
  output logic [2:0]         x_idx,
  output logic [2:0]         y_idx
);

  typedef enum logic [1:0] {IDLE, WALK, COPY, DONE} state_t;

  state_t             state_q, state_d;
  logic [memsize-1:0] work_q, work_d, mem_q, mem_d;
  logic [2:0]         x_q, x_d, y_q, y_d, rnd_q, rnd_d;
  logic [4:0]         sum, s1, s2, col, src_idx, dst_idx;
  logic               last;

  // 2x+3y peaks at 20, so three cascaded subtracts fully reduce it mod 5
  always_comb begin
    sum     = {1'b0, x_q, 1'b0} + {2'b00, y_q} + {1'b0, y_q, 1'b0};
    s1      = (sum >= 5'd15) ? sum - 5'd15 : sum;
    s2      = (s1  >= 5'd10) ? s1  - 5'd10 : s1;
    col     = (s2  >= 5'd5)  ? s2  - 5'd5  : s2;
    src_idx = {y_q, 2'b00} + {2'b00, y_q} + col;
    dst_idx = {x_q, 2'b00} + {2'b00, x_q} + {2'b00, y_q};
    last    = (x_q == 3'd4) && (y_q == 3'd4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      mem_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mem_q   <= mem_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mem_d   = mem_q;
    x_d     = x_q;
    y_d     = y_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: if (start) begin
        work_d  = line;
        mem_d   = '0;
        x_d     = '0;
        y_d     = '0;
        rnd_d   = '0;
        state_d = WALK;
      end
      WALK: begin
        mem_d[dst_idx] = work_q[src_idx];
        if (last) begin
          // wrap indices here so x_idx/y_idx stay within 0..4
          x_d     = '0;
          y_d     = '0;
          state_d = (rnd_q == 3'(ROUNDS - 1)) ? DONE : COPY;
        end else if (y_q == 3'd4) begin
          y_d = '0;
          x_d = x_q + 3'd1;
        end else begin
          y_d = y_q + 3'd1;
        end
      end
      COPY: begin
        work_d  = mem_q;
        mem_d   = '0;
        x_d     = '0;
        y_d     = '0;
        rnd_d   = rnd_q + 3'd1;
        state_d = WALK;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == WALK) || (state_q == COPY);
    done = (state_q == DONE);
  end

  assign mem   = mem_q;
  assign x_idx = x_q;
  assign y_idx = y_q;

endmodule

// File: tb/tb_pi_decoder_module.sv
// Bench for pi_decoder_module: one ROUNDS=1 and one ROUNDS=2 instance against a plane-level model.
module tb_pi_decoder_module;

  logic        clk, rst, start1, start2;
  logic [24:0] line;
  logic        busy1, done1, busy2, done2;
  logic [24:0] mem1, mem2;
  logic [2:0]  xi1, yi1, xi2, yi2;

  int n_cmp = 0, n_err = 0;
  int busy_bad = 0, range_bad = 0, walk_bad = 0;

  pi_decoder_module #(.memsize(25), .ROUNDS(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .line(line), .busy(busy1), .done(done1),
    .mem(mem1), .x_idx(xi1), .y_idx(yi1));

  pi_decoder_module #(.memsize(25), .ROUNDS(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .line(line), .busy(busy2), .done(done2),
    .mem(mem2), .x_idx(xi2), .y_idx(yi2));

  initial clk = 0;
  always #5 clk = ~clk;

  // encoder: cell (x,y) moves to (y, (2x+3y) mod 5)
  function automatic logic [24:0] enc(input logic [24:0] p);
    logic [24:0] e = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        e[5*y + (2*x+3*y)%5] = p[5*x + y];
    return e;
  endfunction

  function automatic logic [24:0] dec(input logic [24:0] e);
    logic [24:0] d = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        d[5*x + y] = e[5*y + (2*x+3*y)%5];
    return d;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // one decode on instance s; lat counts edges after the accepting edge until done is seen
  task automatic run(input bit s, input logic [24:0] ln, input int chg_at,
                     output logic [24:0] res, output int lat);
    line = ln;
    if (s) start2 = 1; else start1 = 1;
    step;
    start1 = 0; start2 = 0;
    lat = 0;
    while (!(s ? done2 : done1) && lat < 200) begin
      if (!(s ? busy2 : busy1)) busy_bad++;
      if ((s ? xi2 : xi1) > 4 || (s ? yi2 : yi1) > 4) range_bad++;
      if (!s && lat < 25 && (int'(xi1) * 5 + int'(yi1)) != lat) walk_bad++;
      step;
      lat++;
      if (lat == chg_at) line = 25'($urandom);
    end
    res = s ? mem2 : mem1;
    if (s ? busy2 : busy1) busy_bad++;
    step;
  endtask

  initial begin
    logic [24:0] res, p, ln;
    int lat, t, first, second;
    bit saw, b26, b27;
    int inb[4]  = '{2, 8, 20, 0};
    int outb[4] = '{5, 1, 24, 0};

    rst = 1; start1 = 0; start2 = 0; line = '0;
    step; step;
    rst = 0;
    chk("rst_mem", 32'(mem1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_done", 32'(done1), 32'h0);
    chk("rst_x", 32'(xi1), 32'h0);
    chk("rst_y", 32'(yi1), 32'h0);

    // abort a decode with reset at E10
    line = 25'h1FFFFFF; start1 = 1;
    step;
    start1 = 0;
    repeat (9) step;
    rst = 1;
    step;
    rst = 0;
    chk("abort_busy", 32'(busy1), 32'h0);
    chk("abort_mem", 32'(mem1), 32'h0);
    chk("abort_x", 32'(xi1), 32'h0);
    saw = 0;
    repeat (40) begin
      if (done1) saw = 1;
      step;
    end
    chk("abort_nodone", 32'(saw), 32'h0);

    for (int i = 0; i < 4; i++) begin
      ln = 25'h1 << inb[i];
      run(0, ln, -1, res, lat);
      chk($sformatf("single_%0d", inb[i]), 32'(res), 32'(25'h1 << outb[i]));
      chk($sformatf("lat_%0d", inb[i]), 32'(lat), 32'd25);
    end

    walk_bad = 0;
    run(0, 25'h1FFFFFF, -1, res, lat);
    chk("all_ones", 32'(res), 32'h1FFFFFF);
    chk("walk_order", 32'(walk_bad), 32'h0);

    for (int i = 0; i < 225; i++) begin
      p = (i < 25) ? (25'h1 << i) : 25'($urandom);
      run(0, enc(p), -1, res, lat);
      chk($sformatf("roundtrip_%0d", i), 32'(res), 32'(p));
    end
    chk("walk_all", 32'(walk_bad), 32'h0);

    busy_bad = 0;
    run(1, 25'h1 << 2, -1, res, lat);
    chk("r2_bit2", 32'(res), 32'(dec(dec(25'h1 << 2))));
    chk("r2_lat", 32'(lat), 32'd51);
    chk("r2_busy", 32'(busy_bad), 32'h0);
    for (int i = 0; i < 5; i++) begin
      p = 25'($urandom);
      run(1, enc(enc(p)), -1, res, lat);
      chk($sformatf("r2_rt_%0d", i), 32'(res), 32'(p));
    end

    p = 25'($urandom);
    run(0, enc(p), 4, res, lat);
    chk("line_change", 32'(res), 32'(p));

    // start held high: one done per decode, restart right after done clears
    p = 25'($urandom);
    line = enc(p); start1 = 1;
    step;
    t = 0; first = -1; second = -1; b26 = 0; b27 = 0;
    while (t < 120 && second < 0) begin
      step;
      t++;
      if (t == 26) b26 = busy1;
      if (t == 27) b27 = busy1;
      if (done1) begin
        if (first < 0) first = t; else second = t;
      end
    end
    start1 = 0;
    chk("hold_first", 32'(first), 32'd25);
    chk("hold_second", 32'(second), 32'd52);
    chk("hold_idle", 32'(b26), 32'h0);
    chk("hold_restart", 32'(b27), 32'h1);
    chk("hold_mem", 32'(mem1), 32'(p));
    step;

    chk("idx_range", 32'(range_bad), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
